// File: rtl/fir_par_gen.sv
// Sliding six-tap window generator feeding the DWT FIR MAC.
// One sample is captured per clock. All six taps are presented in parallel.
// Every second full window is flagged to give the 2:1 analysis decimation.
module fir_par_gen #(
    parameter int w_in = 15
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic signed [w_in-1:0] data_in,
    output logic                   valid_wire,
    output logic signed [w_in-1:0] data_out_0_wire,
    output logic signed [w_in-1:0] data_out_1_wire,
    output logic signed [w_in-1:0] data_out_2_wire,
    output logic signed [w_in-1:0] data_out_3_wire,
    output logic signed [w_in-1:0] data_out_4_wire,
    output logic signed [w_in-1:0] data_out_5_wire
);

    localparam logic [2:0] cnt_full = 3'd6;

    logic signed [w_in-1:0] tap [6];
    logic [2:0]             cnt;
    logic                   ph;

    // Shift the window, count fill up to saturation, and toggle the decimation phase.
    always_ff @(posedge clk) begin
        if (rstn) begin
            for (int k = 0; k < 6; k++) begin
                tap[k] <= '0;
            end
            cnt <= '0;
            ph  <= 1'b0;
        end else begin
            tap[0] <= data_in;
            for (int k = 1; k < 6; k++) begin
                tap[k] <= tap[k-1];
            end
            if (cnt != cnt_full) begin
                cnt <= cnt + 3'd1;
            end
            ph <= ~ph;
        end
    end

    // The phase bit is low after an even number of captures, so a full window
    // is flagged on the 6th, 8th, 10th... sample.
    assign valid_wire      = (cnt == cnt_full) && !ph;
    assign data_out_0_wire = tap[0];
    assign data_out_1_wire = tap[1];
    assign data_out_2_wire = tap[2];
    assign data_out_3_wire = tap[3];
    assign data_out_4_wire = tap[4];
    assign data_out_5_wire = tap[5];

endmodule

// File: tb/tb_fir_par_gen.sv
// Directed and random bench for fir_par_gen with a scoreboard of expected windows.
module tb_fir_par_gen;

    localparam int W = 15;

    typedef struct packed {
        logic                v;
        logic [5:0][W-1:0]   t;
    } exp_t;

    logic                clk;
    logic                rstn;
    logic signed [W-1:0] data_in;
    logic                valid_wire;
    logic signed [W-1:0] data_out_0_wire;
    logic signed [W-1:0] data_out_1_wire;
    logic signed [W-1:0] data_out_2_wire;
    logic signed [W-1:0] data_out_3_wire;
    logic signed [W-1:0] data_out_4_wire;
    logic signed [W-1:0] data_out_5_wire;

    int   total = 0;
    int   bad   = 0;
    int   hist[$];
    int   n_cap = 0;
    exp_t sb[$];

    fir_par_gen #(.w_in(W)) dut (
        .clk             (clk),
        .rstn            (rstn),
        .data_in         (data_in),
        .valid_wire      (valid_wire),
        .data_out_0_wire (data_out_0_wire),
        .data_out_1_wire (data_out_1_wire),
        .data_out_2_wire (data_out_2_wire),
        .data_out_3_wire (data_out_3_wire),
        .data_out_4_wire (data_out_4_wire),
        .data_out_5_wire (data_out_5_wire)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [W-1:0] tap_of(input int k);
        case (k)
            0: tap_of = data_out_0_wire;
            1: tap_of = data_out_1_wire;
            2: tap_of = data_out_2_wire;
            3: tap_of = data_out_3_wire;
            4: tap_of = data_out_4_wire;
            default: tap_of = data_out_5_wire;
        endcase
    endfunction

    // One clock: drive inputs, predict the window, then compare after the edge.
    task automatic step(input logic r, input int d);
        exp_t e;
        @(negedge clk);
        rstn    = r;
        data_in = W'(d);
        @(posedge clk);
        if (r) begin
            hist.delete();
            n_cap = 0;
        end else begin
            hist.push_front(d);
            if (hist.size() > 6) void'(hist.pop_back());
            n_cap++;
        end
        e.v = (n_cap >= 6) && (n_cap % 2 == 0);
        for (int k = 0; k < 6; k++) begin
            e.t[k] = (k < hist.size()) ? W'(hist[k]) : '0;
        end
        sb.push_back(e);
        #1;
        total++;
        assert (sb.size() == 1) else begin
            bad++;
            $error("FAIL sb_depth observed=%0d expected=1", sb.size());
        end
        if (sb.size() > 0) begin
            e = sb.pop_front();
            total++;
            assert (valid_wire === e.v) else begin
                bad++;
                $error("FAIL sb_valid n=%0d observed=%b expected=%b", n_cap, valid_wire, e.v);
            end
            for (int k = 0; k < 6; k++) begin
                total++;
                assert (tap_of(k) === e.t[k]) else begin
                    bad++;
                    $error("FAIL sb_tap%0d n=%0d observed=%0d expected=%0d", k, n_cap,
                           $signed(tap_of(k)), $signed(e.t[k]));
                end
            end
        end
    endtask

    // Fixed-value check of the whole window against hand-derived numbers.
    task automatic check_win(input string tag, input int a0, input int a1, input int a2,
                             input int a3, input int a4, input int a5, input logic v);
        int a[6];
        a = '{a0, a1, a2, a3, a4, a5};
        total++;
        assert (valid_wire === v) else begin
            bad++;
            $error("FAIL %s_valid observed=%b expected=%b", tag, valid_wire, v);
        end
        for (int k = 0; k < 6; k++) begin
            total++;
            assert (tap_of(k) === W'(a[k])) else begin
                bad++;
                $error("FAIL %s_tap%0d observed=%0d expected=%0d", tag, k,
                       $signed(tap_of(k)), a[k]);
            end
        end
    endtask

    task automatic check_valid(input string tag, input logic v);
        total++;
        assert (valid_wire === v) else begin
            bad++;
            $error("FAIL %s observed=%b expected=%b", tag, valid_wire, v);
        end
    endtask

    initial begin
        rstn    = 1'b1;
        data_in = W'(123);

        // reset hold with non-zero input
        for (int i = 0; i < 3; i++) step(1'b1, 123);
        check_win("reset", 0, 0, 0, 0, 0, 0, 1'b0);

        // fill
        for (int i = 1; i <= 5; i++) begin
            step(1'b0, i);
            check_valid("fill_valid_low", 1'b0);
        end
        step(1'b0, 6);
        check_win("fill6", 6, 5, 4, 3, 2, 1, 1'b1);

        // decimation
        step(1'b0, 7);
        check_valid("dec7", 1'b0);
        step(1'b0, 8);
        check_win("dec8", 8, 7, 6, 5, 4, 3, 1'b1);
        step(1'b0, 9);
        check_valid("dec9", 1'b0);
        step(1'b0, 10);
        check_win("dec10", 10, 9, 8, 7, 6, 5, 1'b1);

        // extremes, N reaches 16 so the flag is up
        step(1'b0, -16384);
        step(1'b0, 16383);
        step(1'b0, -1);
        step(1'b0, 0);
        step(1'b0, 1);
        step(1'b0, -16384);
        check_win("extreme", -16384, 1, 0, -1, 16383, -16384, 1'b1);

        // mid-stream reset after 9 samples
        step(1'b1, 0);
        for (int i = 1; i <= 9; i++) step(1'b0, 100 + i);
        step(1'b1, 77);
        check_win("midrst", 0, 0, 0, 0, 0, 0, 1'b0);
        for (int i = 20; i <= 24; i++) begin
            step(1'b0, i);
            check_valid("refill_low", 1'b0);
        end
        step(1'b0, 25);
        check_win("refill25", 25, 24, 23, 22, 21, 20, 1'b1);

        // random soak
        for (int i = 0; i < 200; i++) step(1'b0, int'($urandom % 50));

        // final reset clears state
        step(1'b1, 5);
        check_win("final_rst", 0, 0, 0, 0, 0, 0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
